spi_cmd_frontend: RTL
=====================

# spi_cmd_frontend

Clock-domain front end for the SPI peripheral. It oversamples the raw SPI pins (SCK, CS_N, MOSI) in the system clock domain and deserialises MSB-first bytes. A command/address/data state machine turns each transaction into single-cycle register-file write strobes or register-file reads that are serialised back on MISO. It sits directly upstream of the byte register file that drives the quad-data, debug and 7-segment outputs.

## Interface

Parameters:
- `ADDR_BITS`, default 4: register-file address width; address space is 2^ADDR_BITS bytes.

Ports:
- `clk`, input, 1: system clock; the only clock in the block.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `spi_sck`, input, 1: raw SPI clock, asynchronous to `clk`.
- `spi_cs_n`, input, 1: raw chip select, active low, asynchronous.
- `spi_mosi`, input, 1: raw serial data in, asynchronous.
- `spi_miso`, output, 1: serial data out, registered.
- `spi_miso_oe`, output, 1: MISO output enable, registered.
- `wr_en`, output, 1: one-`clk` write strobe.
- `wr_addr`, output, ADDR_BITS: write address, valid with `wr_en`.
- `wr_data`, output, 8: write data, valid with `wr_en`.
- `rd_addr`, output, ADDR_BITS: read address, registered.
- `rd_data`, input, 8: register-file data; valid one `clk` after `rd_addr` changes.
- `active`, output, 1: high while state is not IDLE.

## Operation

- **Synchronisers:** each of `spi_sck`, `spi_cs_n` and `spi_mosi` passes through a 2-flop synchroniser. SCK rise and fall are detected from the synchronised value plus one history flop.
- **SPI mode:** mode 0, MSB first.
  - MOSI is sampled on a detected rise.
  - MISO is updated on a detected fall.
  - A 3-bit counter counts rises and completes a byte on the 8th rise.
- **States:** IDLE, CMD, ADDR, WR_DATA, RD_DATA, IGNORE.
  - IDLE → CMD when synchronised CS_N is low.
  - CMD, on byte complete:
    - 0x02 → ADDR, with the write flag set.
    - 0x03 → ADDR, with the read flag set.
    - Any other value → IGNORE.
  - ADDR, on byte complete: the address register loads `byte[ADDR_BITS-1:0]` (upper bits ignored), then → WR_DATA or RD_DATA.
  - WR_DATA, on each byte complete:
    - `wr_en` pulses for one `clk`, with `wr_addr` = address and `wr_data` = byte.
    - Address then increments modulo 2^ADDR_BITS.
  - RD_DATA, on each byte complete: address increments and a new prefetch starts.
  - IGNORE persists until CS_N goes high.
- **Read prefetch:**
  - When the ADDR byte completes (read) or a RD_DATA byte completes, `rd_addr` is set to the current address on the next `clk`.
  - `rd_data` is loaded into the 8-bit TX shift register one `clk` later.
  - On each detected fall in RD_DATA: `spi_miso` ← TX[7], then TX shifts left with zero fill.
  - The first fall after a byte completes therefore presents bit 7 of the new byte.
- **MISO enable:** `spi_miso_oe` = 1 only in RD_DATA. `spi_miso` is 0 whenever `spi_miso_oe` = 0.
- **CS_N high:** synchronised CS_N high in any state forces the following:
  - state → IDLE, bit counter → 0;
  - any partial byte is discarded and no `wr_en` is issued;
  - `spi_miso_oe` → 0.
- **Simultaneous events:** a byte completing on the same `clk` that CS_N-high is detected is still processed (`wr_en` issued), then the block goes to IDLE.
- **Reset values:** all outputs 0, state IDLE, counters 0, TX register 0x00.

## Timing

- Input-to-detected-edge latency: 3 `clk` (2 synchroniser flops plus 1 edge flop).
- `wr_en` asserts on the `clk` after the 8th detected rise of a data byte.
- Read path: byte complete → `rd_addr` at +1 `clk` → TX loaded at +2 `clk`.
- Required ratio: `clk` ≥ 8× SCK frequency, with SCK high and low times each ≥ 4 `clk`. This guarantees that TX is loaded before the next detected fall and that MISO settles ≥ 1 `clk` before the master's next rise.
- CS_N setup before the first SCK rise ≥ 3 `clk`; CS_N high time between transactions ≥ 3 `clk`.
- Asynchronous `rst_n` assertion takes effect immediately, including mid-transaction. Deassertion is synchronous to the first `clk` after release (externally synchronised).

## Configuration

- `SPI_CMD_STATUS_EN` defined:
  - Command 0x05 goes straight from CMD to RD_DATA with no address byte.
  - TX loads an internal 8-bit write counter instead of `rd_data`. The counter increments on every `wr_en`, wraps 0xFF→0x00, and resets to 0.
  - The counter is re-sampled at each byte boundary.
  - `rd_addr` is unchanged during status reads.
- `SPI_CMD_STATUS_EN` not defined: 0x05 is an unknown command (→ IGNORE, MISO disabled) and the counter is not built.

## Test plan

- **Reset:** hold `rst_n` low mid-transfer → `spi_miso`=0, `spi_miso_oe`=0, `wr_en`=0, `active`=0; after release a new transaction works.
- **Write burst:** CS low, send 0x02 0x03 0xA5 0x5A, CS high → exactly two `wr_en` pulses: (addr 3, 0xA5), then (addr 4, 0x5A).
- **Wrap:** send 0x02 0x1F 0x11 0x22 with ADDR_BITS=4 → writes (addr 0xF, 0x11), then (addr 0x0, 0x22).
- **Read burst:** register model reg[i]=i×0x11; send 0x03 0x0E then 3 dummy bytes → MISO returns 0xEE 0xFF 0x00, and `spi_miso_oe`=1 only during those bytes.
- **Abort:** send 0x02 0x05 plus 4 bits, then CS high → no `wr_en`. A following 0x02 0x05 0x3C → a single write (addr 5, 0x3C).
- **Unknown/status commands:**
  - Send 0x7E 0x12 → no `wr_en`, `spi_miso_oe` stays 0.
  - With `SPI_CMD_STATUS_EN`, after 3 writes send 0x05 + 1 dummy byte → MISO 0x03.

Source files
------------

// File: rtl/spi_cmd_frontend.sv
// spi_cmd_frontend
//   Oversamples raw SPI mode-0 pins in the clk domain, deserialises MSB-first
//   bytes and decodes them into register-file writes (cmd 0x02) or reads
//   (cmd 0x03). Read data is prefetched and shifted out on MISO.
//   Optional feature macro: SPI_CMD_STATUS_EN (cmd 0x05 returns a write counter).
// Ports:
//   clk, rst_n           system clock, async active-low reset
//   spi_sck/cs_n/mosi    raw asynchronous SPI inputs
//   spi_miso, _oe        registered serial output and its enable
//   wr_en/addr/data      single-cycle register-file write strobe
//   rd_addr, rd_data     register-file read port (data valid 1 clk after addr)
//   active               high while the FSM is not idle
module spi_cmd_frontend #(
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_sck,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [7:0]           wr_data,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [7:0]           rd_data,
  output logic                 active
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WR_DATA, S_RD_DATA, S_IGNORE
  } state_t;

  state_t r_state, w_next;

  logic r_sck_s1, r_sck_s2, r_sck_d;
  logic r_cs_s1, r_cs_s2;
  logic r_mosi_s1, r_mosi_s2;
  logic [2:0] r_bitcnt;
  logic [6:0] r_rx;
  logic [7:0] r_tx;
  logic [ADDR_BITS-1:0] r_addr;
  logic r_rd_flag;
  logic r_pf1, r_pf2;

  logic w_rise, w_fall, w_byte_done, w_pf_start, w_rd_upd;
  logic [7:0] w_byte, w_tx_src;

  // Synchronisers plus one history flop on SCK for edge detection.
  // CS_N resets to the deselected level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_d   <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sck_s1  <= spi_sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_d   <= r_sck_s2;
      r_cs_s1   <= spi_cs_n;
      r_cs_s2   <= r_cs_s1;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_rise      = r_sck_s2 & ~r_sck_d;
  assign w_fall      = ~r_sck_s2 & r_sck_d;
  assign w_byte      = {r_rx, r_mosi_s2};
  assign w_byte_done = w_rise && (r_bitcnt == 3'd7) && (r_state != S_IDLE);

`ifdef SPI_CMD_STATUS_EN
  logic       r_status;
  logic [7:0] r_wcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= 1'b0;
      r_wcnt   <= '0;
    end else begin
      if (w_byte_done && r_state == S_CMD) r_status <= (w_byte == 8'h05);
      if (wr_en) r_wcnt <= r_wcnt + 8'd1;
    end
  end

  assign w_pf_start = w_byte_done &&
                      ((r_state == S_ADDR && r_rd_flag) || r_state == S_RD_DATA ||
                       (r_state == S_CMD && w_byte == 8'h05));
  assign w_rd_upd   = r_pf1 & ~r_status;
  assign w_tx_src   = r_status ? r_wcnt : rd_data;
`else
  assign w_pf_start = w_byte_done &&
                      ((r_state == S_ADDR && r_rd_flag) || r_state == S_RD_DATA);
  assign w_rd_upd   = r_pf1;
  assign w_tx_src   = rd_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (!r_cs_s2) w_next = S_CMD;
      S_CMD:
        if (w_byte_done) begin
          if (w_byte == 8'h02 || w_byte == 8'h03) w_next = S_ADDR;
`ifdef SPI_CMD_STATUS_EN
          else if (w_byte == 8'h05)               w_next = S_RD_DATA;
`endif
          else                                    w_next = S_IGNORE;
        end
      S_ADDR: if (w_byte_done) w_next = r_rd_flag ? S_RD_DATA : S_WR_DATA;
      default: ;
    endcase
    // Applied last so a byte completing alongside CS_N high is still decoded.
    if (r_cs_s2) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitcnt    <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_addr      <= '0;
      r_rd_flag   <= 1'b0;
      r_pf1       <= 1'b0;
      r_pf2       <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_addr     <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      wr_en <= 1'b0;

      if (r_cs_s2)                          r_bitcnt <= '0;
      else if (w_rise && r_state != S_IDLE) r_bitcnt <= r_bitcnt + 3'd1;

      if (w_rise) r_rx <= w_byte[6:0];

      if (w_byte_done) begin
        case (r_state)
          S_CMD:  r_rd_flag <= (w_byte == 8'h03);
          S_ADDR: r_addr    <= w_byte[ADDR_BITS-1:0];
          S_WR_DATA: begin
            wr_en   <= 1'b1;
            wr_addr <= r_addr;
            wr_data <= w_byte;
            r_addr  <= r_addr + ADDR_BITS'(1);
          end
          S_RD_DATA: r_addr <= r_addr + ADDR_BITS'(1);
          default: ;
        endcase
      end

      // Prefetch pipeline: address out one clk after the byte boundary,
      // register-file data captured into TX one clk after that.
      r_pf1 <= w_pf_start;
      r_pf2 <= r_pf1;
      if (w_rd_upd) rd_addr <= r_addr;

      if (r_pf2)                                r_tx <= w_tx_src;
      else if (w_fall && r_state == S_RD_DATA)  r_tx <= {r_tx[6:0], 1'b0};

      spi_miso_oe <= (w_next == S_RD_DATA);
      if (w_next != S_RD_DATA)                  spi_miso <= 1'b0;
      else if (w_fall && r_state == S_RD_DATA)  spi_miso <= r_tx[7];
    end
  end

  assign active = (r_state != S_IDLE);

endmodule
